adxl345_spi_engine: RTL and testbench

Parametrised SPI transaction engine for the ADXL345 accelerometer. It sits between the register-command logic (format, measure-mode and axis-data requests) and the sensor pins. It accepts one register transaction per start pulse: a read or write of 1..MAX_BYTES bytes, with the multi-byte bit set automatically. It builds the command byte, shifts SPI mode 3 (CPOL=1, CPHA=1) at a programmable rate, and packs read bytes into a wide result bus with per-byte strobes.

---
 rtl/adxl345_spi_engine.sv | 183 ++++++++++++++++++
 tb/tb_adxl345_spi_engine.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/adxl345_spi_engine.sv
// adxl345_spi_engine: one-transaction-per-start SPI mode-3 master for the
// ADXL345. It builds the {rw, MB, addr} command byte, shifts 1..MAX_BYTES data
// bytes, and packs read bytes into rd_data with a per-byte valid strobe.
module adxl345_spi_engine #(
  parameter int CLK_DIV   = 50,
  parameter int MAX_BYTES = 6,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   rw,
  input  logic [5:0]             addr,
  input  logic [CNT_W-1:0]       byte_count,
  input  logic [8*MAX_BYTES-1:0] wr_data,
  output logic                   busy,
  output logic                   done,
  output logic [8*MAX_BYTES-1:0] rd_data,
  output logic [7:0]             rd_byte,
  output logic                   rd_byte_valid,
  output logic                   CS,
  output logic                   spi_clk,
  output logic                   MOSI,
  input  logic                   MISO
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int BIT_W = CNT_W + 3;
  localparam int TX_W  = 8 * (MAX_BYTES + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [2:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] n_lat;
  logic             rw_lat;
  logic [TX_W-1:0]  tx_sr;
  logic [6:0]       rx_sr;

  logic [CNT_W-1:0] n_req;
  logic [TX_W-1:0]  tx_load;
  logic             phase_end;
  logic             last_bit;
  logic             byte_end;
  logic [CNT_W-1:0] byte_idx;
  logic [7:0]       rx_byte;

  // Clamp the requested length and build the outgoing frame: command byte in
  // the top bits, then data byte 0, 1, ... so a plain left shift sends them
  // in order. Read frames carry zeros after the command.
  always_comb begin
    if (byte_count == '0)
      n_req = CNT_W'(1);
    else if (byte_count > CNT_W'(MAX_BYTES))
      n_req = CNT_W'(MAX_BYTES);
    else
      n_req = byte_count;
    tx_load = '0;
    tx_load[TX_W-1 -: 8] = {rw, (n_req > CNT_W'(1)), addr};
    for (int unsigned i = 0; i < MAX_BYTES; i++)
      tx_load[8*(MAX_BYTES-1-i) +: 8] = rw ? 8'h00 : wr_data[8*i +: 8];
  end

  // Phase/bit decode shared by the sequencer.
  always_comb begin
    phase_end = (div_cnt == DIV_LAST);
    // last bit index of the frame is 8*(N+1)-1 = {N, 3'b111}
    last_bit  = (bit_cnt == {n_lat, 3'b111});
    byte_end  = rw_lat && (bit_cnt[BIT_W-1:3] != '0) && (bit_cnt[2:0] == 3'b111);
    byte_idx  = bit_cnt[BIT_W-1:3] - CNT_W'(1);
    rx_byte   = {rx_sr, MISO};
  end

  // Transaction sequencer: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE,
  // every phase lasting CLK_DIV cycles; all pin outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      n_lat         <= '0;
      rw_lat        <= 1'b0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rd_data       <= '0;
      rd_byte       <= '0;
      rd_byte_valid <= 1'b0;
      CS            <= 1'b1;
      spi_clk       <= 1'b1;
      MOSI          <= 1'b0;
    end else begin
      done          <= 1'b0;
      rd_byte_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SETUP;
            busy    <= 1'b1;
            CS      <= 1'b0;
            spi_clk <= 1'b1;
            n_lat   <= n_req;
            rw_lat  <= rw;
            tx_sr   <= tx_load;
            MOSI    <= tx_load[TX_W-1];
            div_cnt <= '0;
            bit_cnt <= '0;
            if (rw)
              rd_data <= '0;
          end
        end
        SETUP: begin
          if (phase_end) begin
            state   <= SHIFT;
            spi_clk <= 1'b0;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (!phase_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!spi_clk) begin
              // rising edge: sample MISO; the 8th bit of each data byte
              // completes that byte
              spi_clk <= 1'b1;
              rx_sr   <= rx_byte[6:0];
              if (byte_end) begin
                rd_byte       <= rx_byte;
                rd_byte_valid <= 1'b1;
                for (int unsigned i = 0; i < MAX_BYTES; i++)
                  if (byte_idx == CNT_W'(i))
                    rd_data[8*i +: 8] <= rx_byte;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              if (last_bit) begin
                state <= HOLD;
              end else begin
                // falling edge: present the next bit
                spi_clk <= 1'b0;
                tx_sr   <= tx_sr << 1;
                MOSI    <= tx_sr[TX_W-2];
              end
            end
          end
        end
        HOLD: begin
          if (phase_end) begin
            state   <= GAP;
            CS      <= 1'b1;
            MOSI    <= 1'b0;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (phase_end) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adxl345_spi_engine.sv
// Bench for adxl345_spi_engine: table of transactions against a mode-3 slave
// shift register, plus ignored-start and mid-frame reset sequences.
module tb_adxl345_spi_engine;

  localparam int CLK_DIV   = 2;
  localparam int MAX_BYTES = 6;
  localparam int CNT_W     = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rw;
  logic [5:0]  addr;
  logic [CNT_W-1:0] byte_count;
  logic [47:0] wr_data;
  logic        busy;
  logic        done;
  logic [47:0] rd_data;
  logic [7:0]  rd_byte;
  logic        rd_byte_valid;
  logic        CS;
  logic        spi_clk;
  logic        MOSI;
  logic        MISO;

  always #5 clk = ~clk;

  adxl345_spi_engine #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr),
    .byte_count(byte_count), .wr_data(wr_data), .busy(busy), .done(done),
    .rd_data(rd_data), .rd_byte(rd_byte), .rd_byte_valid(rd_byte_valid),
    .CS(CS), .spi_clk(spi_clk), .MOSI(MOSI), .MISO(MISO)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cycle-level monitor, sampled on the falling clk edge.
  logic prev_cs = 1'b1;
  int cs_fall_cyc = 0, cs_rise_cyc = 0, done_cyc = 0, frames = 0;
  int vcnt = 0;
  int vcyc[8];
  logic [7:0] vbyte[8];
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_cs && !CS) begin cs_fall_cyc = cyc; frames++; end
      if (!prev_cs && CS) cs_rise_cyc = cyc;
      if (done) done_cyc = cyc;
      if (rd_byte_valid) begin
        if (vcnt < 8) begin vcyc[vcnt] = cyc; vbyte[vcnt] = rd_byte; end
        vcnt++;
      end
      if (CS) check("sclk_idle_high", 64'(spi_clk), 64'd1);
    end
    prev_cs = CS;
  end

  // Mode-3 slave: drives MISO on falling spi_clk, captures MOSI on rising.
  logic [55:0] slave_out = '0, sh = '0, cap = '0;
  int  rise_cnt = 0;
  time last_mosi_t = 0, last_rise_t = 0;
  always @(negedge CS) begin sh = slave_out; cap = '0; rise_cnt = 0; end
  always @(negedge spi_clk) if (!CS && !rst) begin MISO = sh[55]; sh = sh << 1; end
  always @(posedge spi_clk) if (!CS && !rst) begin
    check("mosi_setup", 64'($time - last_mosi_t >= 20), 64'd1);
    cap = {cap[54:0], MOSI};
    rise_cnt++;
    last_rise_t = $time;
  end
  always @(MOSI) begin
    if (!CS && !rst && rise_cnt > 0)
      check("mosi_hold", 64'($time - last_rise_t >= 20), 64'd1);
    last_mosi_t = $time;
  end

  typedef struct {
    logic        rw;
    logic [5:0]  addr;
    logic [2:0]  bc;
    logic [47:0] wd;
    logic [47:0] sl;   // slave bytes, byte 0 in [7:0]
    int          n;
    logic [7:0]  cmd;
    logic [47:0] rd;
  } vec_t;
  vec_t vt[7];

  task automatic wait_done(input string tag);
    int w = 0;
    while (!done && w < 2000) begin @(posedge clk); #2; w++; end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
    @(negedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int k, f0, prev_rise;
    logic [55:0] exp_d, mask;
    slave_out = {8'hA5, v.sl[7:0], v.sl[15:8], v.sl[23:16], v.sl[31:24], v.sl[39:32], v.sl[47:40]};
    vcnt = 0;
    f0 = frames;
    prev_rise = cs_rise_cyc;
    @(posedge clk); #1;
    rw = v.rw; addr = v.addr; byte_count = v.bc; wr_data = v.wd; start = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    start = 1'b0;
    check({tag, "_busy_rise"}, 64'(busy), 64'd1);
    check({tag, "_cs_low"}, 64'(CS), 64'd0);
    // inputs change after accept; the frame must not follow them
    rw = ~v.rw; addr = ~v.addr; byte_count = 3'd2; wr_data = ~v.wd;
    wait_done(tag);
    check({tag, "_cs_fall_cyc"}, 64'(cs_fall_cyc - k), 64'd0);
    check({tag, "_cs_low_len"}, 64'(cs_rise_cyc - cs_fall_cyc), 64'(2 * (2 + 16 * (v.n + 1))));
    check({tag, "_done_delay"}, 64'(done_cyc - cs_rise_cyc), 64'd2);
    check({tag, "_busy_fall"}, 64'(busy), 64'd0);
    check({tag, "_cs_gap"}, 64'(cs_fall_cyc - prev_rise >= CLK_DIV), 64'd1);
    check({tag, "_frames"}, 64'(frames - f0), 64'd1);
    check({tag, "_rise_cnt"}, 64'(rise_cnt), 64'(8 * (v.n + 1)));
    check({tag, "_cmd"}, 64'(cap[8*v.n +: 8]), 64'(v.cmd));
    exp_d = '0;
    for (int i = 0; i < v.n; i++)
      exp_d = {exp_d[47:0], (v.rw ? 8'h00 : v.wd[8*i +: 8])};
    mask = (56'd1 << (8 * v.n)) - 56'd1;
    check({tag, "_mosi_data"}, 64'(cap & mask), 64'(exp_d));
    check({tag, "_rd_data"}, 64'(rd_data), 64'(v.rd));
    check({tag, "_valid_cnt"}, 64'(vcnt), 64'(v.rw ? v.n : 0));
    for (int j = 0; j < vcnt && j < v.n && j < 8; j++) begin
      check({tag, "_rd_byte"}, 64'(vbyte[j]), 64'(v.sl[8*j +: 8]));
      if (j > 0) check({tag, "_valid_gap"}, 64'(vcyc[j] - vcyc[j-1]), 64'd32);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int f0, w;
    rst = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; byte_count = '0; wr_data = '0; MISO = 1'b1;

    //        rw    addr   bc    wd                   sl                   n  cmd    rd
    vt[0] = '{1'b1, 6'h00, 3'd1, 48'h0,               48'h0000_0000_00E5, 1, 8'h80, 48'h0000_0000_00E5};
    vt[1] = '{1'b0, 6'h31, 3'd1, 48'h0000_0000_0004,  48'hFFFF_FFFF_FFFF, 1, 8'h31, 48'h0000_0000_00E5};
    vt[2] = '{1'b1, 6'h32, 3'd6, 48'h0,               48'h0605_0403_0201, 6, 8'hF2, 48'h0605_0403_0201};
    vt[3] = '{1'b1, 6'h15, 3'd0, 48'h0,               48'hFFFF_FFFF_FF5A, 1, 8'h95, 48'h0000_0000_005A};
    // 7 is the largest count the 3-bit port can carry; clamps to 6
    vt[4] = '{1'b0, 6'h2D, 3'd7, 48'h6655_4433_2211,  48'h0,              6, 8'h6D, 48'h0000_0000_005A};
    vt[5] = '{1'b0, 6'h1E, 3'd3, 48'h0000_000F_55AA,  48'h0,              3, 8'h5E, 48'h0000_0000_005A};
    vt[6] = '{1'b1, 6'h3F, 3'd2, 48'h0,               48'hFFFF_FFFF_7F80, 2, 8'hFF, 48'h0000_0000_7F80};

    repeat (3) @(posedge clk);
    #1;
    check("rst_CS", 64'(CS), 64'd1);
    check("rst_sclk", 64'(spi_clk), 64'd1);
    check("rst_MOSI", 64'(MOSI), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(rd_byte_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_rd_byte", 64'(rd_byte), 64'd0);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 7; i++)
      run_vec(vt[i], $sformatf("v%0d", i));

    // start pulsed while busy: ignored, latched address kept
    slave_out = {8'hA5, 8'h3C, 40'h0};
    vcnt = 0;
    f0 = frames;
    @(posedge clk); #1;
    rw = 1'b1; addr = 6'h0A; byte_count = 3'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rw = 1'b0; addr = 6'h15; byte_count = 3'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ign");
    repeat (60) @(posedge clk);
    #1;
    check("ign_frames", 64'(frames - f0), 64'd1);
    check("ign_rise_cnt", 64'(rise_cnt), 64'd16);
    check("ign_cmd", 64'(cap[15:8]), 64'h8A);
    check("ign_rd_data", 64'(rd_data), 64'h3C);
    check("ign_valid_cnt", 64'(vcnt), 64'd1);

    // reset during bit 3 of the command byte
    @(posedge clk); #1;
    rw = 1'b0; addr = 6'h31; byte_count = 3'd1; wr_data = 48'h04; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (rise_cnt < 3 && w < 500) begin @(posedge clk); #1; w++; end
    check("rstmid_reach_bit3", 64'(w < 500), 64'd1);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rstmid_CS", 64'(CS), 64'd1);
    check("rstmid_sclk", 64'(spi_clk), 64'd1);
    check("rstmid_MOSI", 64'(MOSI), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_rd_data", 64'(rd_data), 64'd0);
    check("rstmid_rd_byte", 64'(rd_byte), 64'd0);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);
    run_vec(vt[2], "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
